// File: rtl/evo_xb_csr_pkg.sv
// Shared constants and types for the XB-side CSR responder.
package evo_xb_csr_pkg;

    localparam int CSR_DWIDTH = 32;
    localparam int CSR_IRQ_W  = 8;

    localparam int unsigned CSR_CTRL     = 0;
    localparam int unsigned CSR_STATUS   = 1;
    localparam int unsigned CSR_SCRATCH  = 2;
    localparam int unsigned CSR_TICK     = 3;
    localparam int unsigned CSR_IRQ_PEND = 4;
    localparam int unsigned CSR_IRQ_MASK = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_BUSY = 1'b1
    } csr_state_t;

endpackage

// File: rtl/evo_xb_csr_irq.sv
// Interrupt pending/mask storage for the CSR responder (built only with EVO_XB_CSR_IRQ_EN).
module evo_xb_csr_irq
    import evo_xb_csr_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_pend_wr,
    input  logic                 i_mask_wr,
    input  logic [CSR_IRQ_W-1:0] i_wdata,
    input  logic [CSR_IRQ_W-1:0] i_src,
    output logic [CSR_IRQ_W-1:0] o_pend,
    output logic [CSR_IRQ_W-1:0] o_mask,
    output logic                 o_irq
);

    logic [CSR_IRQ_W-1:0] r_pend;
    logic [CSR_IRQ_W-1:0] r_mask;
    logic [CSR_IRQ_W-1:0] w_clr;

    assign w_clr = i_pend_wr ? i_wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            // OR-ing the source in last lets a new event win over a same-cycle clear
            r_pend <= (r_pend & ~w_clr) | i_src;
            if (i_mask_wr) begin
                r_mask <= i_wdata;
            end
        end
    end

    assign o_pend = r_pend;
    assign o_mask = r_mask;
    assign o_irq  = |(r_pend & r_mask);

endmodule

// File: rtl/evo_xb_csr_resp.sv
// Avalon-MM CSR responder for the XB side of the BSP CSR bus.
// Optional IRQ pending/mask registers are built when EVO_XB_CSR_IRQ_EN is defined.
module evo_xb_csr_resp
    import evo_xb_csr_pkg::*;
#(
    parameter int                    ADDR_W     = 3,
    parameter int                    RD_LATENCY = 2,
    parameter logic [CSR_DWIDTH-1:0] CTRL_RST   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_i,
    input  logic [ADDR_W-1:0]     avs_csr_address,
    input  logic                  avs_csr_read,
    input  logic                  avs_csr_write,
    input  logic [CSR_DWIDTH-1:0] avs_csr_writedata,
    output logic [CSR_DWIDTH-1:0] avs_csr_readdata,
    output logic                  avs_csr_readdatavalid,
    output logic                  avs_csr_waitrequest,
    input  logic [CSR_DWIDTH-1:0] status_i,
    input  logic [CSR_IRQ_W-1:0]  irq_src_i,
    output logic [CSR_DWIDTH-1:0] ctrl_o,
    output logic                  irq_o
);

    localparam int              CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    csr_state_t            r_state;
    csr_state_t            w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CSR_DWIDTH-1:0] r_ctrl;
    logic [CSR_DWIDTH-1:0] r_scratch;
    logic [CSR_DWIDTH-1:0] r_tick;
    logic [CSR_DWIDTH-1:0] r_rdata;
    logic [CSR_DWIDTH-1:0] w_rd_mux;
    logic [31:0]           w_addr;
    logic                  w_ready;
    logic                  w_rvalid;
    logic                  w_rd_acc;
    logic                  w_wr_acc;

    assign w_addr = 32'(avs_csr_address);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The final RD_BUSY cycle doubles as an accept slot so reads can stream back to back
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b0;
        w_rvalid    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
            end
            RD_BUSY: begin
                if (r_cnt == '0) begin
                    w_ready     = 1'b1;
                    w_rvalid    = !reset;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_wr_acc = w_ready && avs_csr_write;
        w_rd_acc = w_ready && avs_csr_read && !avs_csr_write;
        if (w_rd_acc) begin
            w_state_nxt = RD_BUSY;
            w_cnt_nxt   = CNT_LOAD;
        end
    end

`ifdef EVO_XB_CSR_IRQ_EN
    logic [CSR_IRQ_W-1:0] w_pend;
    logic [CSR_IRQ_W-1:0] w_mask;
    logic                 w_irq;

    evo_xb_csr_irq u_irq (
        .clk       (clk),
        .reset     (reset),
        .i_pend_wr (w_wr_acc && (w_addr == CSR_IRQ_PEND)),
        .i_mask_wr (w_wr_acc && (w_addr == CSR_IRQ_MASK)),
        .i_wdata   (avs_csr_writedata[CSR_IRQ_W-1:0]),
        .i_src     (irq_src_i),
        .o_pend    (w_pend),
        .o_mask    (w_mask),
        .o_irq     (w_irq)
    );

    assign irq_o = w_irq;
`else
    logic w_unused_irq;

    assign w_unused_irq = ^irq_src_i;
    assign irq_o        = 1'b0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (w_addr)
            CSR_CTRL:     w_rd_mux = r_ctrl;
            CSR_STATUS:   w_rd_mux = status_i;
            CSR_SCRATCH:  w_rd_mux = r_scratch;
            CSR_TICK:     w_rd_mux = r_tick;
`ifdef EVO_XB_CSR_IRQ_EN
            CSR_IRQ_PEND: w_rd_mux = CSR_DWIDTH'(w_pend);
            CSR_IRQ_MASK: w_rd_mux = CSR_DWIDTH'(w_mask);
`endif
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl    <= CTRL_RST;
            r_scratch <= '0;
            r_tick    <= '0;
            r_rdata   <= '0;
        end else begin
            r_tick <= r_tick + CSR_DWIDTH'(tick_i);
            if (w_wr_acc && (w_addr == CSR_CTRL)) begin
                r_ctrl <= avs_csr_writedata;
            end
            if (w_wr_acc && (w_addr == CSR_SCRATCH)) begin
                r_scratch <= avs_csr_writedata;
            end
            if (w_rd_acc) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign avs_csr_readdatavalid = w_rvalid;
    assign avs_csr_readdata      = w_rvalid ? r_rdata : '0;
    assign avs_csr_waitrequest   = !w_ready && !reset;
    assign ctrl_o                = r_ctrl;

endmodule

// File: tb/tb_evo_xb_csr_resp.sv
// Directed self-checking bench for evo_xb_csr_resp (RD_LATENCY = 2).
module tb_evo_xb_csr_resp;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_i;
    logic [2:0]  avs_csr_address;
    logic        avs_csr_read;
    logic        avs_csr_write;
    logic [31:0] avs_csr_writedata;
    logic [31:0] avs_csr_readdata;
    logic        avs_csr_readdatavalid;
    logic        avs_csr_waitrequest;
    logic [31:0] status_i;
    logic [7:0]  irq_src_i;
    logic [31:0] ctrl_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    logic        rv;
    logic [31:0] rd;

    always #5 clk = ~clk;

    evo_xb_csr_resp #(
        .ADDR_W     (3),
        .RD_LATENCY (RD_LAT),
        .CTRL_RST   (32'h0000_0000)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .tick_i                (tick_i),
        .avs_csr_address       (avs_csr_address),
        .avs_csr_read          (avs_csr_read),
        .avs_csr_write         (avs_csr_write),
        .avs_csr_writedata     (avs_csr_writedata),
        .avs_csr_readdata      (avs_csr_readdata),
        .avs_csr_readdatavalid (avs_csr_readdatavalid),
        .avs_csr_waitrequest   (avs_csr_waitrequest),
        .status_i              (status_i),
        .irq_src_i             (irq_src_i),
        .ctrl_o                (ctrl_o),
        .irq_o                 (irq_o)
    );

    task do_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_csr_address   = a;
        avs_csr_writedata = d;
        avs_csr_write     = 1'b1;
        @(negedge clk);
        avs_csr_write     = 1'b0;
    endtask

    task do_read(input logic [2:0] a, output logic v, output logic [31:0] d);
        @(negedge clk);
        avs_csr_address = a;
        avs_csr_read    = 1'b1;
        @(negedge clk);
        avs_csr_read    = 1'b0;
        repeat (RD_LAT - 1) @(negedge clk);
        v = avs_csr_readdatavalid;
        d = avs_csr_readdata;
    endtask

    task test_reset;
        reset = 1'b1; tick_i = 1'b0; avs_csr_address = '0; avs_csr_read = 1'b0;
        avs_csr_write = 1'b0; avs_csr_writedata = '0; status_i = '0; irq_src_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (ctrl_o !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp %h", ctrl_o, 32'h0); end
        checks++; if (avs_csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", avs_csr_readdatavalid); end
        checks++; if (avs_csr_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_waitreq got %b exp 0", avs_csr_waitrequest); end
        checks++; if (avs_csr_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", avs_csr_readdata); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq_o); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (avs_csr_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_waitreq_after got %b exp 0", avs_csr_waitrequest); end
    endtask

    task test_ctrl_read;
        do_write(3'd0, 32'hA5A5_0001);
        checks++; if (ctrl_o !== 32'hA5A5_0001) begin errors++; $display("FAIL t1_ctrl_o got %h exp A5A50001", ctrl_o); end
        @(negedge clk);
        avs_csr_address = 3'd0; avs_csr_read = 1'b1;
        checks++; if (avs_csr_waitrequest !== 1'b0) begin errors++; $display("FAIL t1_wr_accept got %b exp 0", avs_csr_waitrequest); end
        @(negedge clk);
        avs_csr_read = 1'b0;
        checks++; if (avs_csr_waitrequest !== 1'b1) begin errors++; $display("FAIL t1_wr_busy got %b exp 1", avs_csr_waitrequest); end
        checks++; if (avs_csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %b exp 0", avs_csr_readdatavalid); end
        @(negedge clk);
        checks++; if (avs_csr_readdatavalid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b exp 1", avs_csr_readdatavalid); end
        checks++; if (avs_csr_readdata !== 32'hA5A5_0001) begin errors++; $display("FAIL t1_rdata got %h exp A5A50001", avs_csr_readdata); end
        checks++; if (avs_csr_waitrequest !== 1'b0) begin errors++; $display("FAIL t1_wr_release got %b exp 0", avs_csr_waitrequest); end
        @(negedge clk);
        checks++; if (avs_csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL t1_valid_len got %b exp 0", avs_csr_readdatavalid); end
        checks++; if (avs_csr_readdata !== 32'h0) begin errors++; $display("FAIL t1_rdata_idle got %h exp 0", avs_csr_readdata); end
    endtask

    task test_back_to_back;
        do_write(3'd2, 32'h1234_5678);
        status_i = 32'h0000_00C3;
        @(negedge clk);
        avs_csr_address = 3'd2; avs_csr_read = 1'b1;
        @(negedge clk);
        avs_csr_address = 3'd1;
        checks++; if (avs_csr_waitrequest !== 1'b1) begin errors++; $display("FAIL t2_hold_wr got %b exp 1", avs_csr_waitrequest); end
        @(negedge clk);
        checks++; if (avs_csr_readdatavalid !== 1'b1) begin errors++; $display("FAIL t2_v1 got %b exp 1", avs_csr_readdatavalid); end
        checks++; if (avs_csr_readdata !== 32'h1234_5678) begin errors++; $display("FAIL t2_d1 got %h exp 12345678", avs_csr_readdata); end
        checks++; if (avs_csr_waitrequest !== 1'b0) begin errors++; $display("FAIL t2_accept2 got %b exp 0", avs_csr_waitrequest); end
        @(negedge clk);
        avs_csr_read = 1'b0;
        status_i = 32'h0000_00FF;
        checks++; if (avs_csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL t2_gap got %b exp 0", avs_csr_readdatavalid); end
        checks++; if (avs_csr_waitrequest !== 1'b1) begin errors++; $display("FAIL t2_busy2 got %b exp 1", avs_csr_waitrequest); end
        @(negedge clk);
        checks++; if (avs_csr_readdatavalid !== 1'b1) begin errors++; $display("FAIL t2_v2 got %b exp 1", avs_csr_readdatavalid); end
        checks++; if (avs_csr_readdata !== 32'h0000_00C3) begin errors++; $display("FAIL t2_d2 got %h exp 000000C3", avs_csr_readdata); end
        @(negedge clk);
        checks++; if (avs_csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL t2_no_third got %b exp 0", avs_csr_readdatavalid); end
    endtask

    task test_tick;
        @(negedge clk);
        force dut.r_tick = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_tick;
        tick_i = 1'b1;
        repeat (3) @(negedge clk);
        tick_i = 1'b0;
        do_read(3'd3, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'h0000_0001) begin errors++; $display("FAIL t3_wrap got v=%b %h exp v=1 00000001", rv, rd); end
        @(negedge clk);
        avs_csr_address = 3'd3; avs_csr_read = 1'b1; tick_i = 1'b1;
        @(negedge clk);
        avs_csr_read = 1'b0; tick_i = 1'b0;
        @(negedge clk);
        checks++; if (avs_csr_readdata !== 32'h0000_0001) begin errors++; $display("FAIL t3_pre_inc got %h exp 00000001", avs_csr_readdata); end
        do_write(3'd3, 32'h0000_0000);
        do_read(3'd3, rv, rd);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL t3_ro got %h exp 00000002", rd); end
    endtask

    task test_irq;
`ifdef EVO_XB_CSR_IRQ_EN
        do_write(3'd5, 32'h0000_0001);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL t4_idle got %b exp 0", irq_o); end
        @(negedge clk); irq_src_i = 8'h01;
        @(negedge clk); irq_src_i = 8'h00;
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL t4_set got %b exp 1", irq_o); end
        @(negedge clk);
        avs_csr_address = 3'd4; avs_csr_writedata = 32'h1; avs_csr_write = 1'b1; irq_src_i = 8'h01;
        @(negedge clk);
        avs_csr_write = 1'b0; irq_src_i = 8'h00;
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL t4_set_wins got %b exp 1", irq_o); end
        do_write(3'd4, 32'h0000_0001);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL t4_clear got %b exp 0", irq_o); end
        @(negedge clk); irq_src_i = 8'h02;
        @(negedge clk); irq_src_i = 8'h00;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL t4_masked got %b exp 0", irq_o); end
        do_read(3'd4, rv, rd);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL t4_pend got %h exp 00000002", rd); end
        do_read(3'd5, rv, rd);
        checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL t4_mask got %h exp 00000001", rd); end
        do_write(3'd4, 32'h0000_00FF);
`else
        do_write(3'd5, 32'h0000_00FF);
        @(negedge clk); irq_src_i = 8'hFF;
        @(negedge clk); irq_src_i = 8'h00;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL t4_irq_off got %b exp 0", irq_o); end
        do_read(3'd4, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL t4_pend_unmapped got v=%b %h exp v=1 0", rv, rd); end
        do_read(3'd5, rv, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL t4_mask_unmapped got %h exp 0", rd); end
`endif
    endtask

    task test_unmapped_collision;
        do_read(3'd7, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL t5_addr7 got v=%b %h exp v=1 0", rv, rd); end
        @(negedge clk);
        avs_csr_address = 3'd2; avs_csr_writedata = 32'hCAFE_F00D;
        avs_csr_read = 1'b1; avs_csr_write = 1'b1;
        @(negedge clk);
        avs_csr_read = 1'b0; avs_csr_write = 1'b0;
        checks++; if (avs_csr_waitrequest !== 1'b0) begin errors++; $display("FAIL t5_no_busy got %b exp 0", avs_csr_waitrequest); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (avs_csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL t5_no_valid cyc %0d got %b exp 0", i, avs_csr_readdatavalid); end
        end
        do_read(3'd2, rv, rd);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL t5_write_done got %h exp CAFEF00D", rd); end
    endtask

    task test_reset_in_busy;
        do_write(3'd0, 32'h0000_BEEF);
        @(negedge clk);
        avs_csr_address = 3'd2; avs_csr_read = 1'b1;
        @(negedge clk);
        avs_csr_read = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (avs_csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL t6_valid got %b exp 0", avs_csr_readdatavalid); end
        checks++; if (avs_csr_waitrequest !== 1'b0) begin errors++; $display("FAIL t6_waitreq got %b exp 0", avs_csr_waitrequest); end
        checks++; if (ctrl_o !== 32'h0) begin errors++; $display("FAIL t6_ctrl got %h exp 0", ctrl_o); end
        @(negedge clk);
        checks++; if (avs_csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL t6_valid_late got %b exp 0", avs_csr_readdatavalid); end
        do_read(3'd2, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL t6_scratch got v=%b %h exp v=1 0", rv, rd); end
        do_read(3'd3, rv, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL t6_tick got %h exp 0", rd); end
    endtask

    initial begin
        test_reset;
        test_ctrl_read;
        test_back_to_back;
        test_tick;
        test_irq;
        test_unmapped_collision;
        test_reset_in_busy;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
